// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared encodings and constants for the maze key controller
// Key vectors are active-low throughout; direction indices address both Keyboard and i_Wall.
package maze_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEBOUNCE  = 3'd1,
    MOVE      = 3'd2,
    WAIT_DRAW = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam int MAZE_DIM     = 16;
  localparam int MOVE_CNT_MAX = 999;

  localparam logic [3:0] KEYS_NONE = 4'b1111;

  function automatic logic one_key(input logic [3:0] keys);
    return $countones(~keys) == 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - key synchronizer plus free-running stability counter
// The counter restarts on clr_i and saturates; the FSM decides what "stable" means per state.
module key_debounce #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [3:0]       key_raw_i,
  input  logic             clr_i,
  output logic [3:0]       key_sync_o,
  output logic [CNT_W-1:0] stable_cnt_o
);

  logic [3:0]       meta_q;
  logic [3:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
      cnt_q  <= '0;
    end else begin
      meta_q <= key_raw_i;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign key_sync_o   = sync_q;
  assign stable_cnt_o = cnt_q;

endmodule

// File: rtl/maze_key_ctrl.sv
// rtl/maze_key_ctrl.sv - key-driven maze player position controller
// Debounced single-key presses move the player one cell; walls, edges and a reached goal turn moves into bumps.
module maze_key_ctrl
  import maze_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int GOAL_X       = 15,
  parameter int GOAL_Y       = 15
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Keyboard,
  input  logic       fDrawDone,
  input  logic [3:0] i_Wall,
  output logic [3:0] o_PosX,
  output logic [3:0] o_PosY,
  output logic       o_fMove,
  output logic       o_fBump,
  output logic [9:0] o_MoveCnt,
  output logic       o_fGoal,
  output logic [3:0] o_LED
);

  // The IDLE sample that opens DEBOUNCE counts as the first of the stable samples.
  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYC - 2);
  localparam logic [15:0] REL_LAST = 16'(DEBOUNCE_CYC - 1);
  localparam logic [3:0]  POS_MAX  = 4'(MAZE_DIM - 1);

  state_t      state_q, state_d;
  logic [3:0]  key_sync;
  logic [3:0]  key_q, key_d;
  logic [15:0] stable_cnt;
  logic        cnt_clr;
  logic [3:0]  pos_x_q, pos_x_d;
  logic [3:0]  pos_y_q, pos_y_d;
  logic [9:0]  move_cnt_q, move_cnt_d;
  logic        goal_q, goal_d;
  logic        move_q, move_d;
  logic        bump_q, bump_d;
  logic [3:0]  dir;
  logic        at_edge;
  logic        legal;

  key_debounce #(.CNT_W(16)) u_key_debounce (
    .clk_i       (Clk),
    .rst_ni      (Rst),
    .key_raw_i   (Keyboard),
    .clr_i       (cnt_clr),
    .key_sync_o  (key_sync),
    .stable_cnt_o(stable_cnt)
  );

  assign dir     = ~key_q;
  assign at_edge = (dir[DIR_UP]    && (pos_y_q == 4'd0))    ||
                   (dir[DIR_DOWN]  && (pos_y_q == POS_MAX)) ||
                   (dir[DIR_LEFT]  && (pos_x_q == 4'd0))    ||
                   (dir[DIR_RIGHT] && (pos_x_q == POS_MAX));
  assign legal   = !at_edge && ((dir & i_Wall) == 4'b0000) && !goal_q;
  assign goal_d  = goal_q | ((pos_x_q == 4'(GOAL_X)) && (pos_y_q == 4'(GOAL_Y)));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      key_q      <= KEYS_NONE;
      pos_x_q    <= 4'd0;
      pos_y_q    <= 4'd0;
      move_cnt_q <= 10'd0;
      goal_q     <= 1'b0;
      move_q     <= 1'b0;
      bump_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      move_cnt_q <= move_cnt_d;
      goal_q     <= goal_d;
      move_q     <= move_d;
      bump_q     <= bump_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    move_cnt_d = move_cnt_q;
    move_d     = 1'b0;
    bump_d     = 1'b0;
    cnt_clr    = 1'b1;
    case (state_q)
      IDLE: begin
        if (one_key(key_sync)) begin
          key_d   = key_sync;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        cnt_clr = 1'b0;
        if (key_sync != key_q) begin
          state_d = IDLE;
        end else if (stable_cnt == DEB_LAST) begin
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (legal) begin
          if (dir[DIR_UP]) begin
            pos_y_d = pos_y_q - 4'd1;
          end else if (dir[DIR_DOWN]) begin
            pos_y_d = pos_y_q + 4'd1;
          end else if (dir[DIR_LEFT]) begin
            pos_x_d = pos_x_q - 4'd1;
          end else begin
            pos_x_d = pos_x_q + 4'd1;
          end
          if (move_cnt_q != 10'(MOVE_CNT_MAX)) begin
            move_cnt_d = move_cnt_q + 10'd1;
          end
          move_d  = 1'b1;
          state_d = WAIT_DRAW;
        end else begin
          bump_d  = 1'b1;
          state_d = RELEASE;
        end
      end
      WAIT_DRAW: begin
        if (fDrawDone) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Any key seen here restarts the quiet window, so a held key never repeats.
        if (key_sync == KEYS_NONE) begin
          cnt_clr = 1'b0;
          if (stable_cnt == REL_LAST) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_PosX    = pos_x_q;
  assign o_PosY    = pos_y_q;
  assign o_fMove   = move_q;
  assign o_fBump   = bump_q;
  assign o_MoveCnt = move_cnt_q;
  assign o_fGoal   = goal_q;
  assign o_LED     = (state_q == IDLE) ? 4'b0000 : ~key_sync;

endmodule

// File: tb/tb_maze_key_ctrl.sv
// tb/tb_maze_key_ctrl.sv - self-checking bench for maze_key_ctrl
// A timestamp-based press/draw/release model is compared every cycle; directed scenarios add literal checks.
module tb_maze_key_ctrl;

  localparam int DC = 16;
  localparam int GX = 15;
  localparam int GY = 15;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [3:0] Keyboard = 4'b1111;
  logic       fDrawDone = 1'b0;
  logic [3:0] i_Wall = 4'b0000;
  logic [3:0] o_PosX, o_PosY, o_LED;
  logic       o_fMove, o_fBump, o_fGoal;
  logic [9:0] o_MoveCnt;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  maze_key_ctrl #(.DEBOUNCE_CYC(DC), .GOAL_X(GX), .GOAL_Y(GY)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Keyboard (Keyboard),
    .fDrawDone(fDrawDone),
    .i_Wall   (i_Wall),
    .o_PosX   (o_PosX),
    .o_PosY   (o_PosY),
    .o_fMove  (o_fMove),
    .o_fBump  (o_fBump),
    .o_MoveCnt(o_MoveCnt),
    .o_fGoal  (o_fGoal),
    .o_LED    (o_LED)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: ready -> press (stable for DC cycles) -> draw/release -> ready.
  typedef enum int {M_READY, M_PRESS, M_DRAW, M_REL} mph_t;
  mph_t       m_ph;
  logic [3:0] m_s1, m_s2, m_key, old_sync;
  int         m_t, m_quiet, m_cyc, m_x, m_y, m_cnt, nx, ny;
  bit         m_goal, m_move, m_bump, old_goal, ok;

  task automatic m_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_key = 4'hF; m_ph = M_READY;
    m_t = 0; m_quiet = 0; m_x = 0; m_y = 0; m_cnt = 0;
    m_goal = 0; m_move = 0; m_bump = 0;
  endtask

  initial begin
    m_cyc = 0;
    m_reset();
    forever begin
      @(posedge Clk);
      if (!Rst) begin
        m_reset();
      end else begin
        old_sync = m_s2;
        old_goal = m_goal;
        m_move = 0;
        m_bump = 0;
        m_goal = old_goal || (m_x == GX && m_y == GY);
        case (m_ph)
          M_READY:
            if (old_sync inside {4'b0111, 4'b1011, 4'b1101, 4'b1110}) begin
              m_key = old_sync; m_t = m_cyc; m_ph = M_PRESS;
            end
          M_PRESS:
            if (m_cyc - m_t == DC) begin
              nx = m_x; ny = m_y;
              case (m_key)
                4'b0111: ny = m_y - 1;
                4'b1011: ny = m_y + 1;
                4'b1101: nx = m_x - 1;
                default: nx = m_x + 1;
              endcase
              ok = nx >= 0 && nx <= 15 && ny >= 0 && ny <= 15 &&
                   ((i_Wall & ~m_key) == 4'b0000) && !old_goal;
              if (ok) begin
                m_x = nx; m_y = ny;
                m_cnt = (m_cnt >= 999) ? 999 : m_cnt + 1;
                m_move = 1; m_ph = M_DRAW;
              end else begin
                m_bump = 1; m_ph = M_REL; m_quiet = 0;
              end
            end else if (old_sync != m_key) begin
              m_ph = M_READY;
            end
          M_DRAW:
            if (fDrawDone) begin
              m_ph = M_REL; m_quiet = 0;
            end
          default: begin
            m_quiet = (old_sync == 4'hF) ? m_quiet + 1 : 0;
            if (m_quiet == DC) m_ph = M_READY;
          end
        endcase
        m_s2 = m_s1;
        m_s1 = Keyboard;
      end
      m_cyc++;
    end
  end

  logic [3:0] exp_led;
  initial begin
    forever begin
      @(negedge Clk);
      if (cmp_en && Rst) begin
        exp_led = (m_ph == M_READY) ? 4'h0 : ~m_s2;
        check("m_posx", int'(o_PosX), m_x);
        check("m_posy", int'(o_PosY), m_y);
        check("m_cnt", int'(o_MoveCnt), m_cnt);
        check("m_goal", int'(o_fGoal), int'(m_goal));
        check("m_move", int'(o_fMove), int'(m_move));
        check("m_bump", int'(o_fBump), int'(m_bump));
        check("m_led", int'(o_LED), int'(exp_led));
        check("move_bump_excl", int'(o_fMove & o_fBump), 0);
      end
    end
  end

  // Key is already applied; returns pulse latency in edges and pulse counts.
  task automatic watch(input int hold, input int dd, output int lat, output int nm, output int nb);
    int draw_at;
    lat = -1; nm = 0; nb = 0; draw_at = -1;
    for (int i = 1; i <= hold + DC + 10; i++) begin
      @(negedge Clk);
      if (o_fMove || o_fBump) begin
        if (lat < 0) lat = i;
        if (o_fMove) begin
          nm++;
          if (dd >= 0) draw_at = i + dd;
        end else begin
          nb++;
        end
      end
      fDrawDone = (i == draw_at);
      if (i == hold) Keyboard = 4'hF;
    end
    fDrawDone = 1'b0;
  endtask

  task automatic press(input logic [3:0] key, input int hold, input int dd,
                       output int lat, output int nm, output int nb);
    Keyboard = key;
    watch(hold, dd, lat, nm, nb);
  endtask

  task automatic reset_check(input string tag);
    @(negedge Clk);
    #3 Rst = 1'b0;
    #1;
    check({tag, "_posx"}, int'(o_PosX), 0);
    check({tag, "_posy"}, int'(o_PosY), 0);
    check({tag, "_cnt"}, int'(o_MoveCnt), 0);
    check({tag, "_goal"}, int'(o_fGoal), 0);
    check({tag, "_move"}, int'(o_fMove), 0);
    check({tag, "_bump"}, int'(o_fBump), 0);
    check({tag, "_led"}, int'(o_LED), 0);
  endtask

  task automatic release_rst();
    repeat (2) @(negedge Clk);
    #3 Rst = 1'b1;
  endtask

  int lat, nm, nb, pulses, ledon, total;

  initial begin
    repeat (3) @(negedge Clk);
    check("rst_posx", int'(o_PosX), 0);
    check("rst_posy", int'(o_PosY), 0);
    check("rst_cnt", int'(o_MoveCnt), 0);
    check("rst_goal", int'(o_fGoal), 0);
    check("rst_led", int'(o_LED), 0);
    check("rst_pulse", int'(o_fMove | o_fBump), 0);
    Rst = 1'b1;
    cmp_en = 1'b1;
    repeat (4) @(negedge Clk);

    press(4'b1110, 40, 5, lat, nm, nb);
    check("right_latency", lat, 19);
    check("right_nmove", nm, 1);
    check("right_nbump", nb, 0);
    check("right_posx", int'(o_PosX), 1);
    check("right_posy", int'(o_PosY), 0);
    check("right_cnt", int'(o_MoveCnt), 1);

    press(4'b1101, 30, 5, lat, nm, nb);
    check("left_nmove", nm, 1);
    check("left_posx", int'(o_PosX), 0);

    press(4'b0111, 30, -1, lat, nm, nb);
    check("up_edge_latency", lat, 19);
    check("up_edge_nbump", nb, 1);
    check("up_edge_nmove", nm, 0);
    check("up_edge_posy", int'(o_PosY), 0);
    check("up_edge_cnt", int'(o_MoveCnt), 2);

    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      Keyboard = ((i / 8) % 2 == 0) ? 4'b1110 : 4'b1111;
      @(negedge Clk);
      pulses += int'(o_fMove) + int'(o_fBump);
    end
    Keyboard = 4'hF;
    repeat (DC + 4) @(negedge Clk);
    check("bounce_pulses", pulses, 0);

    pulses = 0; ledon = 0;
    Keyboard = 4'b1001;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      pulses += int'(o_fMove) + int'(o_fBump);
      if (o_LED != 4'b0000) ledon++;
    end
    Keyboard = 4'hF;
    repeat (4) @(negedge Clk);
    check("twokey_pulses", pulses, 0);
    check("twokey_led", ledon, 0);

    i_Wall = 4'b0001;
    press(4'b1110, 30, -1, lat, nm, nb);
    check("wall_nbump", nb, 1);
    check("wall_nmove", nm, 0);
    check("wall_posx", int'(o_PosX), 0);
    i_Wall = 4'b0000;

    press(4'b1110, 200, -1, lat, nm, nb);
    check("nodraw_nmove", nm, 1);
    check("nodraw_nbump", nb, 0);
    press(4'b1101, 40, -1, lat, nm, nb);
    check("waitdraw_ignore", nm + nb, 0);
    check("waitdraw_posx", int'(o_PosX), 1);
    fDrawDone = 1'b1;
    @(negedge Clk);
    fDrawDone = 1'b0;
    repeat (DC + 6) @(negedge Clk);
    press(4'b1101, 30, 5, lat, nm, nb);
    check("afterdraw_latency", lat, 19);
    check("afterdraw_posx", int'(o_PosX), 0);
    check("afterdraw_cnt", int'(o_MoveCnt), 4);

    press(4'b1110, 30, -1, lat, nm, nb);
    reset_check("rst_waitdraw");
    release_rst();
    Keyboard = 4'b1110;
    repeat (10) @(negedge Clk);
    reset_check("rst_debounce");
    release_rst();
    watch(30, 5, lat, nm, nb);
    check("fresh_debounce_latency", lat, 19);
    check("fresh_debounce_posx", int'(o_PosX), 1);
    check("fresh_debounce_cnt", int'(o_MoveCnt), 1);

    reset_check("rst_pre_goal");
    release_rst();
    total = 0;
    for (int k = 0; k < 15; k++) begin
      press(4'b1110, 24, 3, lat, nm, nb);
      total += nm;
    end
    check("row_moves", total, 15);
    check("row_posx", int'(o_PosX), 15);
    press(4'b1110, 24, 3, lat, nm, nb);
    check("right_edge_nbump", nb, 1);
    check("right_edge_posx", int'(o_PosX), 15);
    for (int k = 0; k < 15; k++) begin
      press(4'b1011, 24, 3, lat, nm, nb);
      total += nm;
    end
    check("goal_moves", total, 30);
    check("goal_posy", int'(o_PosY), 15);
    check("goal_cnt", int'(o_MoveCnt), 30);
    check("goal_flag", int'(o_fGoal), 1);
    press(4'b1101, 24, 3, lat, nm, nb);
    check("post_goal_nbump", nb, 1);
    check("post_goal_nmove", nm, 0);
    check("post_goal_posx", int'(o_PosX), 15);
    check("post_goal_flag", int'(o_fGoal), 1);

    Keyboard = 4'b1011;
    repeat (8) @(negedge Clk);
    reset_check("rst_goal");
    Keyboard = 4'hF;
    release_rst();
    repeat (5) @(negedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/maze_key_ctrl.md
MAZE_KEY_CTRL -- requirements
Module: maze_key_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 16, sets the consecutive stable cycles required on the key inputs; legal range 2..65535.
REQ-002 Parameter GOAL_X, default 15, is the goal column; GOAL_Y, default 15, is the goal row.
REQ-003 Clk  in  1  single system clock; all state on rising edge.
REQ-004 Rst  in  1  asynchronous, active-low reset.
REQ-005 Keyboard  in  4  raw asynchronous keys, active-low: [3] up, [2] down, [1] left, [0] right; 4'b1111 means no key pressed.
REQ-006 fDrawDone  in  1  draw-complete strobe from the display stage; sampled level-high.
REQ-007 i_Wall  in  4  wall flags for the current cell, same bit order as Keyboard; 1 means blocked.
REQ-008 o_PosX, o_PosY  out  4 each  player cell coordinates, 0..15.
REQ-009 o_fMove  out  1  one-cycle pulse on each accepted move.
REQ-010 o_fBump  out  1  one-cycle pulse on each rejected move (wall or edge).
REQ-011 o_MoveCnt  out  10  count of accepted moves, binary, saturating at 999.
REQ-012 o_fGoal  out  1  sticky flag set when the position equals (GOAL_X, GOAL_Y).
REQ-013 o_LED  out  4  debounced key state, active-high (1 = pressed).

Function
REQ-014 Keyboard SHALL pass through a 2-flop synchronizer before any use.
REQ-015 The FSM SHALL have five states: IDLE, DEBOUNCE, MOVE, WAIT_DRAW, RELEASE.
REQ-016 In IDLE, a synchronized value with exactly one zero bit SHALL cause a transition to DEBOUNCE and clear the stability counter.
- Any other non-1111 value (two or more keys) SHALL be ignored.
REQ-017 In DEBOUNCE, any change of the synchronized value SHALL return the FSM to IDLE.
- After DEBOUNCE_CYC consecutive equal samples, the FSM SHALL go to MOVE.
REQ-018 Latency: if a single key is applied and held, o_fMove or o_fBump SHALL assert exactly DEBOUNCE_CYC+3 rising edges after the first edge that samples the new raw value.
REQ-019 In MOVE (one cycle):
- If the move is legal (in-range, i_Wall bit clear, o_fGoal low), update the position, pulse o_fMove and go to WAIT_DRAW.
- Otherwise pulse o_fBump and go to RELEASE.
REQ-020 Edge rules: up from Y=0, down from Y=15, left from X=0 and right from X=15 SHALL be rejected; coordinates never wrap.
REQ-021 Axes: up decrements Y, down increments Y, left decrements X, right increments X.
REQ-022 WAIT_DRAW SHALL hold until fDrawDone is sampled high, then go to RELEASE.
- fDrawDone in any other state SHALL be ignored.
REQ-023 RELEASE SHALL require the synchronized keys to read 4'b1111 for DEBOUNCE_CYC consecutive cycles, then go to IDLE.
- A held key SHALL therefore never auto-repeat.
REQ-024 o_MoveCnt SHALL increment by one in the same cycle o_fMove asserts; at 999 it SHALL hold.
REQ-025 o_fGoal SHALL set on the cycle after the position update that reaches the goal.
- It SHALL stay set until reset; once set, every later move SHALL be treated as a bump.
REQ-026 o_LED SHALL equal the inverted synchronized keys while in DEBOUNCE, MOVE, WAIT_DRAW and RELEASE, and SHALL be 0 in IDLE.
REQ-027 o_fMove and o_fBump SHALL never be high in the same cycle.

Reset
REQ-028 Rst low SHALL asynchronously force: state IDLE, synchronizer flops to 4'b1111, counters 0, o_PosX=0, o_PosY=0, o_MoveCnt=0, and o_fMove, o_fBump, o_fGoal, o_LED all 0.
REQ-029 Reset asserted mid-WAIT_DRAW or mid-DEBOUNCE SHALL discard the pending move.
- After release, the FSM SHALL require a fresh full debounce.

Structure
REQ-030 Shared package maze_pkg SHALL hold the FSM state encoding, direction bit indices (UP=3, DOWN=2, LEFT=1, RIGHT=0), MAZE_DIM=16 and MOVE_CNT_MAX=999.
REQ-031 Synchronizer plus stability counter SHALL be one sub-module, key_debounce, instantiated once.
- The FSM, position, counter and goal logic SHALL live in maze_key_ctrl.

Verification (DEBOUNCE_CYC=16)
REQ-032 Reset, then Keyboard=4'b1110 held 40 cycles, with fDrawDone pulsed 5 cycles after o_fMove -> o_fMove at edge 19, PosX=1, PosY=0, MoveCnt=1.
REQ-033 From (0,0), Keyboard=4'b0111 (up) -> o_fBump pulse; position and MoveCnt unchanged.
REQ-034 Keyboard=4'b1110 toggling every 8 cycles for 100 cycles -> no o_fMove or o_fBump pulse.
REQ-035 Keyboard=4'b1001 (two keys) held 50 cycles -> no pulse, o_LED=0.
REQ-036 Hold 4'b1110, give no fDrawDone for 200 cycles -> one o_fMove only, FSM stays in WAIT_DRAW; then fDrawDone plus key release -> IDLE.
REQ-037 Drive the position to (15,15) via 30 legal moves (i_Wall=0) -> o_fGoal=1, MoveCnt=30; the next key press gives o_fBump; Rst low mid-sequence -> all outputs 0 immediately.
